dlbf_data_axis2ram_64b: RTL and testbench
=========================================

# dlbf_data_axis2ram_64b

Capture block for the beamforming data path. It accepts a 64-bit AXI4-Stream from the AI Engine array and writes each beat into an on-chip RAM at a wrapping address. It checks TLAST framing against a programmed block size and asserts `done` after `niter` blocks. Host/checker logic reads the captured data back through a second RAM port on the same clock.

## Interface
Parameters:
- DATA_WIDTH, 64, stream and RAM word width (fixed 64 in this revision)
- RAM_DEPTH, 4096, RAM words
- RAM_READ_LATENCY, 4, readback port latency in cycles (≥2)
- MEM_INIT_FILE, "none", RAM initial contents

Ports (clocking: one clock, `s_axis_clk`; `s_axis_rst` is synchronous, active-high):
- s_axis_clk  in  1  sole clock; RAM ports and all logic
- s_axis_rst  in  1  synchronous active-high reset
- go  in  1  level arm; deassert to abort or re-arm
- done  out  1  capture complete, held until go low
- tlast_err  out  1  sticky framing error
- block_size  in  12  beats per block; 0 means 4096
- niter  in  12  blocks to capture; 0 means never start
- rollover_addr  in  16  write-address wrap point; 0 means RAM_DEPTH
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  64  stream data
- s_axis_tkeep  in  8  byte enables, used as RAM byte write enables
- s_axis_tlast  in  1  end of block
- addra_wire  out  16  current write address
- enb  in  1  readback enable
- addrb  in  16  readback address
- doutb  out  64  readback data

## Operation
- `go` is registered twice (`go_int`) before use. All config inputs are sampled into `*_minus1` registers on the IDLE→RUN transition and held for the whole run.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - tready=0.
  - If go_int=1 and niter≠0: clear wr_addr, block_counter and iter_counter, then go to RUN.
- RUN:
  - tready=1.
  - A beat is accepted when tvalid&tready.
  - On each accepted beat:
    - write tdata to RAM[wr_addr] with wea=tkeep.
    - wr_addr wraps to 0 after rollover−1; otherwise it increments.
    - block_counter wraps to 0 after block_size−1; otherwise it increments.
  - Framing check on each accepted beat: tlast must equal (block_counter==block_size−1). On mismatch, tlast_err is set and stays set until reset. The counters follow block_counter, not tlast.
  - Block end (final beat of a block) increments iter_counter.
  - Block end with iter_counter==niter−1 goes to DONE.
  - go_int=0 goes to IDLE (abort, no done). Data already written stays in RAM.
- DONE:
  - done=1, tready=0.
  - go_int=0 goes to IDLE.
- Counter arithmetic is modulo 12 bits; address arithmetic is modulo 16 bits, truncated to log2(RAM_DEPTH) bits at the RAM.
- The readback port is independent of the FSM. A read of the address being written in the same cycle returns old data.

## Timing
- Reset values: tready=0, done=0, tlast_err=0, addra_wire=0, doutb=0, FSM=IDLE. Reset mid-run applies on the next edge; RAM contents are untouched.
- go→tready=1: 3 cycles (2 sync stages + FSM transition).
- tready is registered. It drops in the cycle after the final beat of block niter is accepted; no further beat is accepted. done rises in that same cycle.
- RAM write occurs 1 cycle after acceptance (registered data/addr/wea). addra_wire shows the pre-increment address of that write.
- Readback: doutb is valid RAM_READ_LATENCY cycles after enb=1 with addrb.
- tvalid may toggle freely. No bubbles are inserted while tready=1, so sustained throughput is 1 beat/cycle.
- tlast_err is registered and rises 1 cycle after the offending beat.

## Structure
- Package `dlbf_data_pkg`: FSM state enum (IDLE/RUN/DONE), CNT_W=12, ADDR_W=16, GO_SYNC_STAGES=2.
- Sub-module: reuse `dlbf_data_xpm_ram`.
  - Port a: write (wea=tkeep), with bram_clk tied to s_axis_clk.
  - Port b: readback (enb/addrb/doutb), with clock s_axis_clk.
- Top level contains the FSM, the three counters, the framing checker and the write pipeline register.

## Test plan
- block_size=8, niter=4, rollover=64, tlast every 8th beat, tvalid continuous → 32 beats written at 0..31, done rises 1 cycle after beat 32, tlast_err=0, readback of 0..31 matches stimulus.
- block_size=4, niter=5, rollover=6 → 20 beats written, addresses wrap 0..5 repeatedly, so RAM[0..5] holds beats 18,19,14,15,16,17.
- tlast asserted on beat 3 of an 8-beat block → tlast_err=1 one cycle later and stays 1; done still asserts after block_size×niter beats.
- Random tvalid gaps (50%), block_size=16, niter=2 → exactly 32 writes; tready is 1 for every cycle in RUN.
- go dropped after 10 of 32 beats → tready=0 within 3 cycles, done stays 0. Re-raise go: writes restart at address 0, and done follows a full 32 beats.
- niter=0 with go=1 → tready stays 0, done stays 0. s_axis_rst pulse mid-run → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/dlbf_data_pkg.sv
`default_nettype none
// ============================================================================
// dlbf_data_pkg
// Shared widths and FSM encoding for the beamforming data capture path.
// Rev 1.0
// ============================================================================
package dlbf_data_pkg;
   localparam int CNT_W          = 12;
   localparam int ADDR_W         = 16;
   localparam int GO_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/dlbf_data_xpm_ram.sv
`default_nettype none
// ============================================================================
// dlbf_data_xpm_ram
// Simple dual-port RAM: byte-enabled write port a, pipelined read port b.
// Rev 1.0
// ============================================================================
module dlbf_data_xpm_ram #(
   parameter int DATA_WIDTH    = 64,
   parameter int RAM_DEPTH     = 4096,
   parameter int READ_LATENCY  = 4,
   parameter     MEM_INIT_FILE = "none",
   parameter int RAM_AW        = $clog2(RAM_DEPTH)
) (
   input  logic                    bram_clk,
   input  logic                    ena,
   input  logic [DATA_WIDTH/8-1:0] wea,
   input  logic [RAM_AW-1:0]       addra,
   input  logic [DATA_WIDTH-1:0]   dina,
   input  logic                    clkb,
   input  logic                    rst,
   input  logic                    enb,
   input  logic [RAM_AW-1:0]       addrb,
   output logic [DATA_WIDTH-1:0]   doutb
);
   localparam int C_NB = DATA_WIDTH / 8;
   // Contents are not preloaded in this revision; the name is kept for drop-in use.
   localparam bit c_unused_init = (MEM_INIT_FILE != "none");

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_pipe [READ_LATENCY];

   always_ff @(posedge bram_clk) begin
      if (ena) begin
         for (int b = 0; b < C_NB; b++) begin
            if (wea[b]) mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
         end
      end
   end

   // Read-before-write: a same-cycle read of the write address sees old data.
   always_ff @(posedge clkb) begin
      if (rst) begin
         for (int i = 0; i < READ_LATENCY; i++) r_rd_pipe[i] <= '0;
      end else begin
         if (enb) r_rd_pipe[0] <= mem[addrb];
         for (int i = 1; i < READ_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
   end

   assign doutb = r_rd_pipe[READ_LATENCY-1];
endmodule
`default_nettype wire

// File: rtl/dlbf_data_axis2ram_64b.sv
`default_nettype none
// ============================================================================
// dlbf_data_axis2ram_64b
// Captures niter blocks of a 64-bit AXI4-Stream into RAM with TLAST framing check.
// Rev 1.0
// ============================================================================
module dlbf_data_axis2ram_64b
   import dlbf_data_pkg::*;
#(
   parameter int DATA_WIDTH       = 64,
   parameter int RAM_DEPTH        = 4096,
   parameter int RAM_READ_LATENCY = 4,
   parameter     MEM_INIT_FILE    = "none"
) (
   input  logic                    s_axis_clk,
   input  logic                    s_axis_rst,
   input  logic                    go,
   output logic                    done,
   output logic                    tlast_err,
   input  logic [CNT_W-1:0]        block_size,
   input  logic [CNT_W-1:0]        niter,
   input  logic [ADDR_W-1:0]       rollover_addr,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic [ADDR_W-1:0]       addra_wire,
   input  logic                    enb,
   input  logic [ADDR_W-1:0]       addrb,
   output logic [DATA_WIDTH-1:0]   doutb
);
   localparam int                C_RAM_AW   = $clog2(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] C_DEPTH_M1 = ADDR_W'(RAM_DEPTH - 1);

   logic [GO_SYNC_STAGES-1:0] r_go_sync;
   state_t                    r_state;
   logic                      r_tready;
   logic                      r_done;
   logic                      r_tlast_err;
   logic [ADDR_W-1:0]         r_wr_addr;
   logic [CNT_W-1:0]          r_blk_cnt;
   logic [CNT_W-1:0]          r_iter_cnt;
   logic [CNT_W-1:0]          r_bs_minus1;
   logic [CNT_W-1:0]          r_niter_minus1;
   logic [ADDR_W-1:0]         r_roll_minus1;
   logic                      r_wr_en;
   logic [DATA_WIDTH/8-1:0]   r_wea;
   logic [DATA_WIDTH-1:0]     r_wr_data;
   logic [ADDR_W-1:0]         r_addra;

   logic w_go_int;
   logic w_accept;
   logic w_blk_end;

   assign w_go_int  = r_go_sync[GO_SYNC_STAGES-1];
   assign w_accept  = s_axis_tvalid & r_tready;
   assign w_blk_end = (r_blk_cnt == r_bs_minus1);

   always_ff @(posedge s_axis_clk) begin
      if (s_axis_rst) begin
         r_go_sync      <= '0;
         r_state        <= IDLE;
         r_tready       <= 1'b0;
         r_done         <= 1'b0;
         r_tlast_err    <= 1'b0;
         r_wr_addr      <= '0;
         r_blk_cnt      <= '0;
         r_iter_cnt     <= '0;
         r_bs_minus1    <= '0;
         r_niter_minus1 <= '0;
         r_roll_minus1  <= '0;
         r_wr_en        <= 1'b0;
         r_wea          <= '0;
         r_wr_data      <= '0;
         r_addra        <= '0;
      end else begin
         r_go_sync <= {r_go_sync[GO_SYNC_STAGES-2:0], go};

         // Write pipeline: addra_wire reports the address of the write in flight.
         r_wr_en <= w_accept;
         r_wea   <= w_accept ? s_axis_tkeep : '0;
         if (w_accept) begin
            r_wr_data <= s_axis_tdata;
            r_addra   <= r_wr_addr;
         end

         case (r_state)
            IDLE: begin
               r_tready <= 1'b0;
               r_done   <= 1'b0;
               if (w_go_int && (niter != '0)) begin
                  r_wr_addr      <= '0;
                  r_blk_cnt      <= '0;
                  r_iter_cnt     <= '0;
                  r_bs_minus1    <= block_size - 1'b1;
                  r_niter_minus1 <= niter - 1'b1;
                  r_roll_minus1  <= (rollover_addr == '0) ? C_DEPTH_M1 : rollover_addr - 1'b1;
                  r_tready       <= 1'b1;
                  r_state        <= RUN;
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_wr_addr <= (r_wr_addr == r_roll_minus1) ? '0 : r_wr_addr + 1'b1;
                  r_blk_cnt <= w_blk_end ? '0 : r_blk_cnt + 1'b1;
                  if (s_axis_tlast != w_blk_end) r_tlast_err <= 1'b1;
                  if (w_blk_end) begin
                     r_iter_cnt <= r_iter_cnt + 1'b1;
                     if (r_iter_cnt == r_niter_minus1) begin
                        r_state  <= DONE;
                        r_tready <= 1'b0;
                        r_done   <= 1'b1;
                     end
                  end
               end
               // An abort wins over a simultaneous final beat; the beat is still written.
               if (!w_go_int) begin
                  r_state  <= IDLE;
                  r_tready <= 1'b0;
                  r_done   <= 1'b0;
               end
            end
            DONE: begin
               r_tready <= 1'b0;
               if (!w_go_int) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_tready <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign s_axis_tready = r_tready;
   assign done          = r_done;
   assign tlast_err     = r_tlast_err;
   assign addra_wire    = r_addra;

   if (C_RAM_AW < ADDR_W) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^{addrb[ADDR_W-1:C_RAM_AW], r_addra[ADDR_W-1:C_RAM_AW]};
   end

   dlbf_data_xpm_ram #(
      .DATA_WIDTH    (DATA_WIDTH),
      .RAM_DEPTH     (RAM_DEPTH),
      .READ_LATENCY  (RAM_READ_LATENCY),
      .MEM_INIT_FILE (MEM_INIT_FILE),
      .RAM_AW        (C_RAM_AW)
   ) u_ram (
      .bram_clk (s_axis_clk),
      .ena      (r_wr_en),
      .wea      (r_wea),
      .addra    (r_addra[C_RAM_AW-1:0]),
      .dina     (r_wr_data),
      .clkb     (s_axis_clk),
      .rst      (s_axis_rst),
      .enb      (enb),
      .addrb    (addrb[C_RAM_AW-1:0]),
      .doutb    (doutb)
   );
endmodule
`default_nettype wire

// File: tb/tb_dlbf_data_axis2ram_64b.sv
`default_nettype none
// ============================================================================
// tb_dlbf_data_axis2ram_64b
// Directed bench with a beat-level capture model and per-cycle output compare.
// Rev 1.0
// ============================================================================
module tb_dlbf_data_axis2ram_64b;
   localparam int RL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        done;
   logic        tlast_err;
   logic [11:0] block_size = '0;
   logic [11:0] niter = '0;
   logic [15:0] rollover_addr = '0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [63:0] tdata = '0;
   logic [7:0]  tkeep = '0;
   logic        tlast = 1'b0;
   logic [15:0] addra_wire;
   logic        enb = 1'b0;
   logic [15:0] addrb = '0;
   logic [63:0] doutb;

   always #5 clk = ~clk;

   dlbf_data_axis2ram_64b #(
      .DATA_WIDTH(64), .RAM_DEPTH(4096), .RAM_READ_LATENCY(RL), .MEM_INIT_FILE("none")
   ) dut (
      .s_axis_clk(clk), .s_axis_rst(rst), .go(go), .done(done), .tlast_err(tlast_err),
      .block_size(block_size), .niter(niter), .rollover_addr(rollover_addr),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
      .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .addra_wire(addra_wire),
      .enb(enb), .addrb(addrb), .doutb(doutb)
   );

   int checks = 0;
   int failures = 0;

   // Model state: beats observed this run, sticky framing error, expected RAM image.
   int          m_bs = 1, m_roll = 1, m_total = 0, m_n = 0;
   bit          m_err = 1'b0, m_fsm_chk = 1'b0;
   logic [63:0] mem_m [4096];
   bit          mem_v [4096];
   bit          pend = 1'b0;
   int          pend_addr = 0;
   bit          keep_mode = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pat(input int tag, input int k);
      return {8'(tag), 8'hA5, 16'(k), ~32'(k * 7 + tag)};
   endfunction

   function automatic logic [7:0] kp(input int k);
      return (keep_mode && k == 9) ? 8'h3C : 8'hFF;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         pend  = 1'b0;
         m_err = 1'b0;
      end else begin
         if (pend) begin
            chk("addra_wire", addra_wire, 64'(pend_addr));
            chk("tlast_err", tlast_err, 64'(m_err));
            if (m_fsm_chk) begin
               chk("done_after_beat", done, 64'(m_n == m_total));
               chk("tready_after_beat", tready, 64'(m_n != m_total));
            end
            pend = 1'b0;
         end else if (m_fsm_chk && m_n > 0 && m_n < m_total) begin
            chk("tready_in_run", tready, 1);
         end
         if (tvalid && tready) begin
            if (m_fsm_chk) chk("beat_within_run", 64'(m_n < m_total), 1);
            pend_addr = m_n % m_roll;
            if (tlast != ((m_n % m_bs) == m_bs - 1)) m_err = 1'b1;
            for (int b = 0; b < 8; b++)
               if (tkeep[b]) mem_m[pend_addr % 4096][b*8 +: 8] = tdata[b*8 +: 8];
            mem_v[pend_addr % 4096] = mem_v[pend_addr % 4096] | (tkeep == 8'hFF);
            m_n++;
            pend = 1'b1;
         end
      end
   end

   task automatic start_run(input int bs, input int ni, input int roll, input bit fchk);
      block_size    = 12'(bs);
      niter         = 12'(ni);
      rollover_addr = 16'(roll);
      m_bs      = (bs == 0) ? 4096 : bs;
      m_roll    = (roll == 0) ? 4096 : roll;
      m_total   = m_bs * ni;
      m_n       = 0;
      m_fsm_chk = fchk;
      go = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("go_latency_2cyc", tready, 0);
      @(posedge clk);
      #1 chk("go_latency_3cyc", tready, 1);
   endtask

   task automatic send(input int nb, input int bs, input bit gaps, input int bad, input int tag);
      int k = 0;
      int cyc = 0;
      bit acc;
      while (k < nb) begin
         tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         tdata  = pat(tag, k);
         tkeep  = kp(k);
         tlast  = (((k % bs) == bs - 1) != (k == bad));
         @(negedge clk);
         acc = tvalid && tready;
         @(posedge clk);
         #1;
         if (acc) k++;
         cyc++;
         if (cyc > 3000) begin
            checks++; failures++;
            $display("FAIL send_timeout: got %0d beats expected %0d", k, nb);
            break;
         end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic end_run();
      tvalid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("done_held", done, 1);
      chk("tready_in_done", tready, 0);
      tvalid = 1'b0;
      go = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("done_clear_on_go_low", done, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input int a, input logic [63:0] exp, input string name);
      enb   = 1'b1;
      addrb = 16'(a);
      @(posedge clk);
      #1 enb = 1'b0;
      repeat (RL - 1) @(posedge clk);
      #1 chk(name, doutb, exp);
   endtask

   task automatic rd_model(input int lo, input int hi);
      for (int a = lo; a <= hi; a++)
         if (mem_v[a]) rd_chk(a, mem_m[a], "readback_model");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] mask;
      for (int i = 0; i < 4096; i++) begin mem_v[i] = 1'b0; mem_m[i] = '0; end
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_tready", tready, 0);
      chk("rst_done", done, 0);
      chk("rst_tlast_err", tlast_err, 0);
      chk("rst_addra", addra_wire, 0);
      chk("rst_doutb", doutb, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Contiguous capture, 4 blocks of 8.
      start_run(8, 4, 64, 1'b1);
      send(32, 8, 1'b0, -1, 1);
      end_run();
      chk("t1_tlast_err", tlast_err, 0);
      rd_model(0, 31);
      rd_chk(31, pat(1, 31), "t1_ram31");

      // Address wrap at 6 with 20 beats.
      start_run(4, 5, 6, 1'b1);
      send(20, 4, 1'b0, -1, 2);
      end_run();
      rd_chk(0, pat(2, 18), "t2_ram0");
      rd_chk(1, pat(2, 19), "t2_ram1");
      rd_chk(2, pat(2, 14), "t2_ram2");
      rd_chk(3, pat(2, 15), "t2_ram3");
      rd_chk(4, pat(2, 16), "t2_ram4");
      rd_chk(5, pat(2, 17), "t2_ram5");

      // Random tvalid gaps, full-depth rollover.
      start_run(16, 2, 0, 1'b1);
      send(32, 16, 1'b1, -1, 4);
      end_run();
      chk("t4_beat_count", 64'(m_n), 32);

      // Early tlast on beat 3 of the first block.
      start_run(8, 2, 64, 1'b1);
      send(16, 8, 1'b0, 2, 3);
      end_run();
      chk("t3_tlast_err_sticky", tlast_err, 1);

      // niter of zero never starts.
      m_fsm_chk = 1'b0;
      block_size = 12'd8; niter = 12'd0; rollover_addr = 16'd64;
      go = 1'b1; tvalid = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("niter0_tready", tready, 0);
      chk("niter0_done", done, 0);
      go = 1'b0; tvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of a run.
      start_run(8, 4, 64, 1'b1);
      send(5, 8, 1'b0, -1, 7);
      m_fsm_chk = 1'b0;
      rst = 1'b1; go = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_tready", tready, 0);
      chk("midrst_done", done, 0);
      chk("midrst_tlast_err", tlast_err, 0);
      chk("midrst_addra", addra_wire, 0);
      chk("midrst_doutb", doutb, 0);
      repeat (3) @(posedge clk);
      #1;

      // Abort after 10 beats, then a full restart with a partial keep on beat 9.
      start_run(8, 4, 64, 1'b0);
      send(10, 8, 1'b0, -1, 5);
      go = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_tready", tready, 0);
      chk("abort_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
      keep_mode = 1'b1;
      start_run(8, 4, 64, 1'b1);
      send(32, 8, 1'b0, -1, 6);
      end_run();
      keep_mode = 1'b0;
      rd_chk(0, pat(6, 0), "t5_restart_addr0");
      mask = 64'h0000_FFFF_FFFF_0000;
      rd_chk(9, (pat(6, 9) & mask) | (pat(5, 9) & ~mask), "t5_byte_enable_merge");
      rd_model(0, 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
